// File: rtl/filter_addr_pkg.sv
// Shared types and widths for the filter read-address sequencer.
package filter_addr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Filter-index width: ceil(log2(n)), never below one bit.
  function automatic int unsigned calc_nf_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned ADDR_WIDTH      = 16;
  localparam int unsigned I_WIDTH         = 4;
  localparam int unsigned NUM_FILTERS_MAX = 4;
  localparam int unsigned NF_WIDTH        = calc_nf_width(NUM_FILTERS_MAX);
  localparam int unsigned LEN_WIDTH       = I_WIDTH + 1;
  localparam int unsigned NFC_WIDTH       = NF_WIDTH + 1;
  localparam int unsigned REP_WIDTH       = 4;

endpackage

// File: rtl/filter_addr_sequencer_if.sv
// Start/config, read-address stream and status bundle of the sequencer.
// FILTER_ADDR_REPEAT_EN adds the cfg_repeat field.
interface filter_addr_sequencer_if import filter_addr_pkg::*;;

  logic                  start;
  logic [ADDR_WIDTH-1:0] cfg_base_addr;
  logic [LEN_WIDTH-1:0]  cfg_filter_len;
  logic [NFC_WIDTH-1:0]  cfg_num_filters;
  logic                  cfg_interleaved;
`ifdef FILTER_ADDR_REPEAT_EN
  logic [REP_WIDTH-1:0]  cfg_repeat;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [NF_WIDTH-1:0]   filt_idx;
  logic [I_WIDTH-1:0]    elem_idx;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport master (
`ifdef FILTER_ADDR_REPEAT_EN
    output cfg_repeat,
`endif
    output start, cfg_base_addr, cfg_filter_len, cfg_num_filters, cfg_interleaved,
    output out_ready,
    input  out_valid, read_addr, filt_idx, elem_idx, out_last, busy, done
  );

  modport slave (
`ifdef FILTER_ADDR_REPEAT_EN
    input  cfg_repeat,
`endif
    input  start, cfg_base_addr, cfg_filter_len, cfg_num_filters, cfg_interleaved,
    input  out_ready,
    output out_valid, read_addr, filt_idx, elem_idx, out_last, busy, done
  );

endinterface

// File: rtl/filter_addr_step.sv
// Combinational successor of one beat position: next (addr, row_base, i, f)
// and whether that next beat closes the pass.
module filter_addr_step
  import filter_addr_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] row_base,
  input  logic [I_WIDTH-1:0]    i,
  input  logic [NF_WIDTH-1:0]   f,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [NFC_WIDTH-1:0]  nf,
  input  logic                  interleaved,
  output logic [ADDR_WIDTH-1:0] next_addr_c,
  output logic [ADDR_WIDTH-1:0] next_row_base_c,
  output logic [I_WIDTH-1:0]    next_i_c,
  output logic [NF_WIDTH-1:0]   next_f_c,
  output logic                  next_last_c
);

  logic f_wrap;

  always_comb begin
    next_addr_c     = addr;
    next_row_base_c = row_base;
    next_i_c        = i;
    next_f_c        = f + NF_WIDTH'(1);
    f_wrap          = (NFC_WIDTH'(f) == nf - NFC_WIDTH'(1));

    if (f_wrap) begin
      next_f_c = '0;
      next_i_c = i + I_WIDTH'(1);
    end

    // Contiguous layout jumps a whole filter per f step and returns to the next row on wrap.
    if (interleaved) begin
      next_addr_c = addr + ADDR_WIDTH'(1);
    end else if (f_wrap) begin
      next_row_base_c = row_base + ADDR_WIDTH'(1);
      next_addr_c     = row_base + ADDR_WIDTH'(1);
    end else begin
      next_addr_c = addr + ADDR_WIDTH'(len);
    end

    next_last_c = (LEN_WIDTH'(next_i_c) == len - LEN_WIDTH'(1)) &&
                  (NFC_WIDTH'(next_f_c) == nf - NFC_WIDTH'(1));
  end

endmodule

// File: rtl/filter_addr_sequencer.sv
// Streams filter-weight read addresses over valid/ready, one per accepted beat.
// FILTER_ADDR_REPEAT_EN replays the whole sequence cfg_repeat+1 times.
module filter_addr_sequencer
  import filter_addr_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  filter_addr_sequencer_if.slave  bus
);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [NFC_WIDTH-1:0]  nf_q, nf_d;
  logic                  inter_q, inter_d;
  logic [REP_WIDTH-1:0]  rep_q, rep_d;
  logic [REP_WIDTH-1:0]  rep_cnt_q, rep_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [I_WIDTH-1:0]    i_q, i_d;
  logic [NF_WIDTH-1:0]   f_q, f_d;
  logic                  pass_last_q, pass_last_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH-1:0] step_addr, step_row_base;
  logic [I_WIDTH-1:0]    step_i;
  logic [NF_WIDTH-1:0]   step_f;
  logic                  step_last;
  logic [NFC_WIDTH-1:0]  nf_clamp_c;
  logic [REP_WIDTH-1:0]  rep_cfg_c;
  logic                  single_beat_c;

  filter_addr_step u_step (
    .addr            (addr_q),
    .row_base        (row_base_q),
    .i               (i_q),
    .f               (f_q),
    .len             (len_q),
    .nf              (nf_q),
    .interleaved     (inter_q),
    .next_addr_c     (step_addr),
    .next_row_base_c (step_row_base),
    .next_i_c        (step_i),
    .next_f_c        (step_f),
    .next_last_c     (step_last)
  );

  assign nf_clamp_c = (bus.cfg_num_filters > NFC_WIDTH'(NUM_FILTERS_MAX)) ?
                      NFC_WIDTH'(NUM_FILTERS_MAX) : bus.cfg_num_filters;
`ifdef FILTER_ADDR_REPEAT_EN
  assign rep_cfg_c = bus.cfg_repeat;
`else
  assign rep_cfg_c = '0;
`endif
  // A pass of exactly one beat closes on its first beat.
  assign single_beat_c = (len_q == LEN_WIDTH'(1)) && (nf_q == NFC_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    nf_d        = nf_q;
    inter_d     = inter_q;
    rep_d       = rep_q;
    rep_cnt_d   = rep_cnt_q;
    addr_d      = addr_q;
    row_base_d  = row_base_q;
    i_d         = i_q;
    f_d         = f_q;
    pass_last_d = pass_last_q;
    last_d      = last_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.cfg_base_addr;
          len_d   = bus.cfg_filter_len;
          nf_d    = nf_clamp_c;
          inter_d = bus.cfg_interleaved;
          rep_d   = rep_cfg_c;
          if (bus.cfg_filter_len != '0 && nf_clamp_c != '0) begin
            state_d     = RUN;
            valid_d     = 1'b1;
            busy_d      = 1'b1;
            addr_d      = bus.cfg_base_addr;
            row_base_d  = bus.cfg_base_addr;
            i_d         = '0;
            f_d         = '0;
            rep_cnt_d   = '0;
            pass_last_d = (bus.cfg_filter_len == LEN_WIDTH'(1)) &&
                          (nf_clamp_c == NFC_WIDTH'(1));
            last_d      = pass_last_d && (rep_cfg_c == '0);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (valid_q && bus.out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else if (pass_last_q) begin
            // Replay the sequence from the top with no bubble.
            addr_d      = base_q;
            row_base_d  = base_q;
            i_d         = '0;
            f_d         = '0;
            rep_cnt_d   = rep_cnt_q + REP_WIDTH'(1);
            pass_last_d = single_beat_c;
            last_d      = single_beat_c && (rep_cnt_d == rep_q);
          end else begin
            addr_d      = step_addr;
            row_base_d  = step_row_base;
            i_d         = step_i;
            f_d         = step_f;
            pass_last_d = step_last;
            last_d      = step_last && (rep_cnt_q == rep_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      len_q       <= '0;
      nf_q        <= '0;
      inter_q     <= 1'b0;
      rep_q       <= '0;
      rep_cnt_q   <= '0;
      addr_q      <= '0;
      row_base_q  <= '0;
      i_q         <= '0;
      f_q         <= '0;
      pass_last_q <= 1'b0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      base_q      <= base_d;
      len_q       <= len_d;
      nf_q        <= nf_d;
      inter_q     <= inter_d;
      rep_q       <= rep_d;
      rep_cnt_q   <= rep_cnt_d;
      addr_q      <= addr_d;
      row_base_q  <= row_base_d;
      i_q         <= i_d;
      f_q         <= f_d;
      pass_last_q <= pass_last_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.read_addr = addr_q;
  assign bus.filt_idx  = f_q;
  assign bus.elem_idx  = i_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_filter_addr_sequencer.sv
// Self-checking bench for filter_addr_sequencer against a nested-loop address model.
// Honours FILTER_ADDR_REPEAT_EN when defined.
module tb_filter_addr_sequencer;
  import filter_addr_pkg::*;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [NF_WIDTH-1:0]   f;
    logic [I_WIDTH-1:0]    i;
    logic                  last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks;
  int   n_fail;

  filter_addr_sequencer_if bus ();

  filter_addr_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // mode 0: ready always high, 1: random ready, 2: three-cycle stall on beat 2
  task automatic run_seq(input string name, input logic [ADDR_WIDTH-1:0] base,
                         input int len, input int nf_cfg, input bit inter, input int rep,
                         input int mode, input int poke_at, input int abort_at);
    beat_t exp[$];
    beat_t b;
    int    nf, rp, total, acc, cyc, stall;
    bit    rdy, poked;
    rp = rep;
`ifndef FILTER_ADDR_REPEAT_EN
    rp = 0;
`endif
    nf = (nf_cfg > int'(NUM_FILTERS_MAX)) ? int'(NUM_FILTERS_MAX) : nf_cfg;
    for (int p = 0; p <= rp; p++)
      for (int i = 0; i < len; i++)
        for (int f = 0; f < nf; f++) begin
          b.addr = base + ADDR_WIDTH'(inter ? (i * nf + f) : (f * len + i));
          b.f    = NF_WIDTH'(f);
          b.i    = I_WIDTH'(i);
          b.last = (p == rp) && (i == len - 1) && (f == nf - 1);
          exp.push_back(b);
        end
    total = exp.size();

    @(negedge clk);
    bus.cfg_base_addr   = base;
    bus.cfg_filter_len  = LEN_WIDTH'(len);
    bus.cfg_num_filters = NFC_WIDTH'(nf_cfg);
    bus.cfg_interleaved = inter;
`ifdef FILTER_ADDR_REPEAT_EN
    bus.cfg_repeat      = REP_WIDTH'(rp);
`endif
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    if (total == 0) begin
      n_checks++;
      if ({bus.done, bus.out_valid, bus.busy} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s degenerate_done: done/valid/busy=%b required 100", name,
                 {bus.done, bus.out_valid, bus.busy});
      end
      @(negedge clk);
      n_checks++;
      if ({bus.done, bus.out_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s degenerate_after: done/valid=%b required 00", name,
                 {bus.done, bus.out_valid});
      end
      return;
    end

    acc = 0; cyc = 0; stall = 0; poked = 1'b0;
    while (1) begin
      if (exp.size() == 0) begin
        n_checks++;
        if ({bus.done, bus.busy, bus.out_valid, bus.out_last} !== 4'b1000) begin
          n_fail++;
          $display("FAIL %s end_of_run: done/busy/valid/last=%b required 1000", name,
                   {bus.done, bus.busy, bus.out_valid, bus.out_last});
        end
        break;
      end
      if (cyc >= 4000) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s timeout: accepted %0d required %0d", name, acc, total);
        break;
      end
      n_checks++;
      if ({bus.out_valid, bus.busy, bus.done} !== 3'b110) begin
        n_fail++;
        $display("FAIL %s run_status beat %0d: valid/busy/done=%b required 110", name, acc,
                 {bus.out_valid, bus.busy, bus.done});
      end
      b = exp[0];
      n_checks++;
      if (bus.read_addr !== b.addr || bus.filt_idx !== b.f || bus.elem_idx !== b.i ||
          bus.out_last !== b.last) begin
        n_fail++;
        $display("FAIL %s beat %0d: addr=%h f=%0d i=%0d last=%b required addr=%h f=%0d i=%0d last=%b",
                 name, acc, bus.read_addr, bus.filt_idx, bus.elem_idx, bus.out_last,
                 b.addr, b.f, b.i, b.last);
      end
      if (acc == abort_at) begin
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.out_last, bus.done} !== 4'b0000) begin
          n_fail++;
          $display("FAIL %s async_reset: valid/busy/last/done=%b required 0000", name,
                   {bus.out_valid, bus.busy, bus.out_last, bus.done});
        end
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(acc == 2 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      // Config inputs wander during the run; only the latched copy may matter.
      bus.cfg_base_addr   = ADDR_WIDTH'($urandom);
      bus.cfg_filter_len  = LEN_WIDTH'($urandom);
      bus.cfg_num_filters = NFC_WIDTH'($urandom);
      bus.cfg_interleaved = 1'($urandom);
      bus.start = (acc == poke_at && !poked);
      if (acc == poke_at) poked = 1'b1;
      bus.out_ready = rdy;
      if (rdy) begin
        void'(exp.pop_front());
        acc++;
      end
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end

    n_checks++;
    if (acc != total || (mode == 0 && cyc != total)) begin
      n_fail++;
      $display("FAIL %s beat_count: beats=%0d cycles=%0d required %0d", name, acc, cyc, total);
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.out_valid, bus.busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s done_pulse_width: done/valid/busy=%b required 000", name,
               {bus.done, bus.out_valid, bus.busy});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.out_last, bus.busy, bus.done} !== 4'b0000 ||
        bus.read_addr !== '0 || bus.filt_idx !== '0 || bus.elem_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid/last/busy/done=%b addr=%h f=%0d i=%0d required all 0",
               {bus.out_valid, bus.out_last, bus.busy, bus.done}, bus.read_addr,
               bus.filt_idx, bus.elem_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_interleaved();
    run_seq("interleaved", 16'h0100, 3, 2, 1'b1, 0, 0, -1, -1);
  endtask

  task automatic test_contiguous();
    run_seq("contiguous", 16'h0010, 3, 2, 1'b0, 0, 0, -1, -1);
    run_seq("contiguous_4x4", 16'h2000, 4, 4, 1'b0, 0, 0, -1, -1);
  endtask

  task automatic test_backpressure();
    run_seq("backpressure", 16'h0100, 3, 2, 1'b1, 0, 2, -1, -1);
    run_seq("random_ready", 16'h0340, 5, 3, 1'b0, 0, 1, -1, -1);
  endtask

  task automatic test_degenerate();
    run_seq("len_zero", 16'h0100, 0, 2, 1'b1, 0, 0, -1, -1);
    run_seq("nf_zero", 16'h0100, 3, 0, 1'b0, 0, 0, -1, -1);
    run_seq("nf_clamp", 16'h0400, 2, 7, 1'b1, 0, 0, -1, -1);
    run_seq("nf_clamp_contig", 16'h0400, 3, 6, 1'b0, 0, 0, -1, -1);
    run_seq("single_beat", 16'h0777, 1, 1, 1'b0, 0, 0, -1, -1);
    run_seq("len_max", 16'h1000, 16, 4, 1'b0, 0, 1, -1, -1);
  endtask

  task automatic test_wrap();
    run_seq("wrap_inter", 16'hFFFE, 2, 2, 1'b1, 0, 0, -1, -1);
    run_seq("wrap_contig", 16'hFFFD, 3, 2, 1'b0, 0, 0, -1, -1);
  endtask

  task automatic test_control();
    run_seq("start_mid_run", 16'h0100, 3, 2, 1'b1, 0, 0, 2, -1);
    run_seq("reset_mid_run", 16'h0100, 3, 2, 1'b1, 0, 0, -1, 2);
    run_seq("restart_after_reset", 16'h0100, 3, 2, 1'b1, 0, 0, -1, -1);
  endtask

  task automatic test_repeat();
    run_seq("repeat_once", 16'h0100, 3, 2, 1'b1, 1, 0, -1, -1);
    run_seq("repeat_single_beat", 16'h0050, 1, 1, 1'b0, 2, 1, -1, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++)
      run_seq("random", ADDR_WIDTH'($urandom), int'($urandom_range(0, 16)),
              int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 8)), -1);
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    rst                 = 1'b1;
    bus.start           = 1'b0;
    bus.cfg_base_addr   = '0;
    bus.cfg_filter_len  = '0;
    bus.cfg_num_filters = '0;
    bus.cfg_interleaved = 1'b0;
`ifdef FILTER_ADDR_REPEAT_EN
    bus.cfg_repeat      = '0;
`endif
    bus.out_ready       = 1'b0;
    test_reset();
    test_interleaved();
    test_contiguous();
    test_backpressure();
    test_degenerate();
    test_wrap();
    test_control();
    test_repeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
